// File: rtl/iob_bus_merge_pkg.sv
// Shared types and helpers for the ibus/dbus merge block.
// Source IDs tag each outstanding read so its response returns to the issuing bus.
package iob_bus_merge_pkg;

    typedef enum logic {
        SRC_IBUS = 1'b0,
        SRC_DBUS = 1'b1
    } src_t;

    // Widest strobe the helper accepts; callers zero-extend narrower strobes.
    localparam int unsigned STRB_MAX_W = 64;

    function automatic logic req_is_read(input logic [STRB_MAX_W-1:0] wstrb);
        return (wstrb == '0);
    endfunction

endpackage

// File: rtl/iob_bus_merge_fifo.sv
// Register FIFO of 1-bit source IDs, depth 2**OUTST_W.
// Push while full and pop while empty are ignored.
module iob_bus_merge_fifo #(
    parameter int OUTST_W = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic cke_i,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int unsigned DEPTH = 1 << OUTST_W;
    localparam logic [OUTST_W:0] DEPTH_C = (OUTST_W + 1)'(DEPTH);

    logic               mem_q [DEPTH];
    logic [OUTST_W-1:0] wptr_q;
    logic [OUTST_W-1:0] rptr_q;
    logic [OUTST_W:0]   count_q;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rptr_q];

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (cke_i) begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (cke_i && do_push) begin
            mem_q[wptr_q] <= din;
        end
    end

endmodule

// File: rtl/iob_bus_merge.sv
// Merges the CPU ibus and dbus IOb-native masters onto one memory port.
// Default is fixed priority (dbus first); define IOB_BUS_MERGE_RR_EN for round-robin.
module iob_bus_merge
    import iob_bus_merge_pkg::*;
#(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int OUTST_W = 2
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                cke_i,

    input  logic                ibus_avalid_i,
    input  logic [ADDR_W-1:0]   ibus_addr_i,
    input  logic [DATA_W-1:0]   ibus_wdata_i,
    input  logic [DATA_W/8-1:0] ibus_wstrb_i,
    output logic [DATA_W-1:0]   ibus_rdata_o,
    output logic                ibus_rvalid_o,
    output logic                ibus_ready_o,

    input  logic                dbus_avalid_i,
    input  logic [ADDR_W-1:0]   dbus_addr_i,
    input  logic [DATA_W-1:0]   dbus_wdata_i,
    input  logic [DATA_W/8-1:0] dbus_wstrb_i,
    output logic [DATA_W-1:0]   dbus_rdata_o,
    output logic                dbus_rvalid_o,
    output logic                dbus_ready_o,

    output logic                mem_avalid_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wstrb_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    input  logic                mem_rvalid_i,
    input  logic                mem_ready_i
);

    localparam int STRB_W = DATA_W / 8;

    src_t                  grant;
    src_t                  grant_q;
    logic                  lock_q;
    logic                  g_avalid;
    logic [STRB_W-1:0]     g_wstrb;
    logic [STRB_MAX_W-1:0] g_wstrb_ext;
    logic                  g_is_read;
    logic                  block;
    logic                  handshake;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;

`ifdef IOB_BUS_MERGE_RR_EN
    src_t                  last_grant;
`endif

    // A locked grant is held until its handshake; otherwise arbitrate fresh.
    always_comb begin
        grant = SRC_IBUS;
        if (lock_q) begin
            grant = grant_q;
        end else if (dbus_avalid_i && ibus_avalid_i) begin
`ifdef IOB_BUS_MERGE_RR_EN
            grant = (last_grant == SRC_IBUS) ? SRC_DBUS : SRC_IBUS;
`else
            grant = SRC_DBUS;
`endif
        end else if (dbus_avalid_i) begin
            grant = SRC_DBUS;
        end
    end

    always_comb begin
        g_avalid    = ibus_avalid_i;
        mem_addr_o  = ibus_addr_i;
        mem_wdata_o = ibus_wdata_i;
        g_wstrb     = ibus_wstrb_i;
        if (grant == SRC_DBUS) begin
            g_avalid    = dbus_avalid_i;
            mem_addr_o  = dbus_addr_i;
            mem_wdata_o = dbus_wdata_i;
            g_wstrb     = dbus_wstrb_i;
        end
        g_wstrb_ext               = '0;
        g_wstrb_ext[STRB_W-1:0]   = g_wstrb;
    end

    assign mem_wstrb_o = g_wstrb;
    assign g_is_read   = req_is_read(g_wstrb_ext);
    // Registered full flag: a same-cycle pop does not unblock a new read.
    assign block       = fifo_full & g_is_read;
    assign mem_avalid_o = g_avalid & ~block;
    assign handshake   = mem_avalid_o & mem_ready_i;

    assign ibus_ready_o = (grant == SRC_IBUS) & mem_ready_i & ~block;
    assign dbus_ready_o = (grant == SRC_DBUS) & mem_ready_i & ~block;

    assign fifo_push = handshake & g_is_read;
    assign fifo_pop  = mem_rvalid_i & ~fifo_empty;

    assign ibus_rdata_o  = mem_rdata_i;
    assign dbus_rdata_o  = mem_rdata_i;
    assign ibus_rvalid_o = fifo_pop & (fifo_dout == SRC_IBUS);
    assign dbus_rvalid_o = fifo_pop & (fifo_dout == SRC_DBUS);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            lock_q  <= 1'b0;
            grant_q <= SRC_IBUS;
        end else if (cke_i) begin
            if (handshake) begin
                lock_q <= 1'b0;
            end else if (mem_avalid_o) begin
                lock_q  <= 1'b1;
                grant_q <= grant;
            end
        end
    end

`ifdef IOB_BUS_MERGE_RR_EN
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            last_grant <= SRC_IBUS;
        end else if (cke_i && handshake) begin
            last_grant <= grant;
        end
    end
`endif

    iob_bus_merge_fifo #(
        .OUTST_W(OUTST_W)
    ) u_fifo (
        .clk_i (clk_i),
        .rstn_i(rstn_i),
        .cke_i (cke_i),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (grant == SRC_DBUS),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
